// File: rtl/lc3b_types.sv
// rtl/lc3b_types.sv - LC-3b word/opcode types and MEM-stage sequencer state.
package lc3b_types;

  typedef logic [15:0] lc3b_word;

  typedef enum logic [3:0] {
    op_br   = 4'b0000,
    op_add  = 4'b0001,
    op_ldb  = 4'b0010,
    op_stb  = 4'b0011,
    op_jsr  = 4'b0100,
    op_and  = 4'b0101,
    op_ldr  = 4'b0110,
    op_str  = 4'b0111,
    op_rti  = 4'b1000,
    op_not  = 4'b1001,
    op_ldi  = 4'b1010,
    op_sti  = 4'b1011,
    op_jmp  = 4'b1100,
    op_shf  = 4'b1101,
    op_lea  = 4'b1110,
    op_trap = 4'b1111
  } lc3b_opcode;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    INDIRECT,
    DONE
  } mem_state;

  function automatic logic is_mem_op(lc3b_opcode op);
    case (op)
      op_ldr, op_ldb, op_str, op_stb, op_ldi, op_sti: return 1'b1;
      default:                                        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_store_formatter.sv
// rtl/mem_store_formatter.sv - Store data replication and byte-lane mask for dcache writes.
module mem_store_formatter
  import lc3b_types::*;
(
  input  lc3b_opcode  opcode,
  input  logic        addr_lsb,
  input  lc3b_word    store_data,
  output lc3b_word    wdata,
  output logic [1:0]  byte_enable
);

  always_comb begin
    wdata       = store_data;
    byte_enable = 2'b11;
    // Byte stores replicate the low byte so either lane carries it.
    if (opcode == op_stb) begin
      wdata       = {store_data[7:0], store_data[7:0]};
      byte_enable = addr_lsb ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage dcache sequencer with LDI/STI pointer indirection.
module mem_access_unit
  import lc3b_types::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_EX_MEM,
  input  lc3b_opcode  opcode_EX_MEM,
  input  lc3b_word    alu_out_EX_MEM,
  input  lc3b_word    store_data_EX_MEM,
  input  logic        dcache_resp,
  input  lc3b_word    dcache_rdata,
  output logic        dcache_read,
  output logic        dcache_write,
  output lc3b_word    dcache_address,
  output lc3b_word    dcache_wdata,
  output logic [1:0]  dcache_byte_enable,
  output lc3b_word    mem_rdata,
  output logic        mem_stall
);

  mem_state   state, state_next;
  lc3b_word   pointer_reg;
  lc3b_word   access_addr;
  lc3b_word   fmt_wdata;
  logic [1:0] fmt_be;
  logic       mem_op, indirect_op, load_op, byte_op;

  assign mem_op      = valid_EX_MEM && is_mem_op(opcode_EX_MEM);
  assign indirect_op = (opcode_EX_MEM == op_ldi) || (opcode_EX_MEM == op_sti);
  assign load_op     = (opcode_EX_MEM == op_ldr) || (opcode_EX_MEM == op_ldb) ||
                       (opcode_EX_MEM == op_ldi);
  assign byte_op     = (opcode_EX_MEM == op_ldb) || (opcode_EX_MEM == op_stb);
  assign access_addr = byte_op ? alu_out_EX_MEM : {alu_out_EX_MEM[15:1], 1'b0};

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pointer_reg <= '0;
      mem_rdata   <= '0;
    end else begin
      state <= state_next;
      if (state == ACCESS && dcache_resp) begin
        if (indirect_op)
          pointer_reg <= dcache_rdata;
        else if (load_op)
          mem_rdata <= dcache_rdata;
      end
      if (state == INDIRECT && dcache_resp && opcode_EX_MEM == op_ldi)
        mem_rdata <= dcache_rdata;
    end
  end

  always_comb begin
    state_next     = state;
    dcache_read    = 1'b0;
    dcache_write   = 1'b0;
    dcache_address = access_addr;
    mem_stall      = 1'b0;
    case (state)
      IDLE: begin
        if (mem_op) begin
          mem_stall  = 1'b1;
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        // STI reads here too: the first access fetches its pointer.
        mem_stall    = 1'b1;
        dcache_read  = load_op || (opcode_EX_MEM == op_sti);
        dcache_write = (opcode_EX_MEM == op_str) || (opcode_EX_MEM == op_stb);
        if (dcache_resp)
          state_next = indirect_op ? INDIRECT : DONE;
      end
      INDIRECT: begin
        mem_stall      = 1'b1;
        dcache_address = {pointer_reg[15:1], 1'b0};
        dcache_read    = (opcode_EX_MEM == op_ldi);
        dcache_write   = (opcode_EX_MEM == op_sti);
        if (dcache_resp)
          state_next = DONE;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  mem_store_formatter u_store_formatter (
    .opcode      (opcode_EX_MEM),
    .addr_lsb    (dcache_address[0]),
    .store_data  (store_data_EX_MEM),
    .wdata       (fmt_wdata),
    .byte_enable (fmt_be)
  );

  assign dcache_wdata       = dcache_write ? fmt_wdata : '0;
  assign dcache_byte_enable = dcache_write ? fmt_be : 2'b11;

endmodule
